// File: rtl/cpu_pkg.sv
// Shared types and widths for the single-issue CPU pipeline.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Optional build macro used by consumers of this package: WB_FWD_EN.
package cpu_pkg;

  localparam int XLEN = 32;  // datapath width
  localparam int RA_W = 6;   // register address width (64 registers)

  typedef enum logic [1:0] {
    BR_NONE = 2'd0,
    BR_Z    = 2'd1,
    BR_N    = 2'd2,
    BR_J    = 2'd3
  } br_type_e;

  // Everything the writeback stage captures from execute.
  typedef struct packed {
    logic [RA_W-1:0] rd;
    logic            reg_write;
    logic            mem_to_reg;
    logic            set_flags;
    br_type_e        br_type;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] result;
    logic            zero;
    logic            neg;
  } wb_fields_t;

endpackage

// File: rtl/branch_resolve.sv
// Resolves BRZ/BRN/J in writeback from the architectural flags.
// Latency: purely combinational.
// Backpressure: redirect is suppressed while hold is high.
//
// Ports:
//   valid_i    - WB register holds a valid instruction
//   hold_i     - stage is frozen by the hazard unit
//   flag_z_i   - registered Z flag (before this instruction's update)
//   flag_n_i   - registered N flag (before this instruction's update)
//   br_type_i  - branch kind of the WB instruction
//   taken_o    - branch condition satisfied (ignores valid/hold)
//   redirect_valid_o - taken branch/jump should redirect the PC now
module branch_resolve
  import cpu_pkg::*;
(
  input  logic     valid_i,
  input  logic     hold_i,
  input  logic     flag_z_i,
  input  logic     flag_n_i,
  input  br_type_e br_type_i,
  output logic     taken_o,
  output logic     redirect_valid_o
);

  always_comb begin
    taken_o = 1'b0;
    unique case (br_type_i)
      BR_Z:    taken_o = flag_z_i;
      BR_N:    taken_o = flag_n_i;
      BR_J:    taken_o = 1'b1;
      default: taken_o = 1'b0;
    endcase
  end

  assign redirect_valid_o = valid_i & taken_o & ~hold_i;

endmodule

// File: rtl/wb_stage.sv
// Execute-to-writeback pipeline register plus writeback: register-file
// write, architectural Z/N flags and PC redirect for BRZ/BRN/J.
// Latency: one cycle EX->WB; writeback/redirect outputs combinational from WB.
// Backpressure: hold freezes all WB state; a load's read data is latched on
// the first held cycle so the write data stays stable until release.
//
// Build option: define WB_FWD_EN to add the fwd_valid/fwd_rd/fwd_data
// bypass ports (same-cycle copies of the register-file write).
//
// Ports:
//   clock, reset_n     - clock and synchronous active-low reset
//   ex_*               - instruction fields from execute
//   mem_rdata          - synchronous data-memory read data (first WB cycle)
//   hold, flush        - hazard-unit stall / squash of the EX instruction
//   wb_valid           - WB register holds a valid instruction
//   rf_we/waddr/wdata  - register-file write port
//   flag_z, flag_n     - architectural flags
//   redirect_valid/pc  - PC redirect for a taken branch/jump
module wb_stage
  import cpu_pkg::*;
(
  input  logic            clock,
  input  logic            reset_n,
  input  logic            ex_valid,
  input  logic [RA_W-1:0] ex_rd,
  input  logic            ex_reg_write,
  input  logic            ex_mem_to_reg,
  input  logic            ex_set_flags,
  input  logic [1:0]      ex_br_type,
  input  logic [XLEN-1:0] ex_target,
  input  logic [XLEN-1:0] ex_result,
  input  logic            ex_zero,
  input  logic            ex_neg,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic            hold,
  input  logic            flush,
  output logic            wb_valid,
  output logic            rf_we,
  output logic [RA_W-1:0] rf_waddr,
  output logic [XLEN-1:0] rf_wdata,
  output logic            flag_z,
  output logic            flag_n,
`ifdef WB_FWD_EN
  output logic            fwd_valid,
  output logic [RA_W-1:0] fwd_rd,
  output logic [XLEN-1:0] fwd_data,
`endif
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc
);

  wb_fields_t      fields_q, fields_d;
  wb_fields_t      ex_fields;
  logic            wb_valid_q, wb_valid_d;
  logic            flag_z_q, flag_z_d;
  logic            flag_n_q, flag_n_d;
  logic            load_held_q, load_held_d;
  logic [XLEN-1:0] load_data_q, load_data_d;
  logic            br_taken;
  logic            br_redirect;

  always_comb begin
    ex_fields            = '0;
    ex_fields.rd         = ex_rd;
    ex_fields.reg_write  = ex_reg_write;
    ex_fields.mem_to_reg = ex_mem_to_reg;
    ex_fields.set_flags  = ex_set_flags;
    ex_fields.br_type    = br_type_e'(ex_br_type);
    ex_fields.target     = ex_target;
    ex_fields.result     = ex_result;
    ex_fields.zero       = ex_zero;
    ex_fields.neg        = ex_neg;
  end

  branch_resolve u_branch_resolve (
    .valid_i          (wb_valid_q),
    .hold_i           (hold),
    .flag_z_i         (flag_z_q),
    .flag_n_i         (flag_n_q),
    .br_type_i        (fields_q.br_type),
    .taken_o          (br_taken),
    .redirect_valid_o (br_redirect)
  );

  always_comb begin
    fields_d    = fields_q;
    wb_valid_d  = wb_valid_q;
    flag_z_d    = flag_z_q;
    flag_n_d    = flag_n_q;
    load_held_d = load_held_q;
    load_data_d = load_data_q;

    if (hold) begin
      // Read data is only presented in the first WB cycle; keep a copy
      // for the rest of the stall.
      if (wb_valid_q && fields_q.mem_to_reg && !load_held_q) begin
        load_data_d = mem_rdata;
        load_held_d = 1'b1;
      end
    end else begin
      fields_d    = ex_fields;
      load_held_d = 1'b0;
      // hold is low here, so valid & taken is exactly the redirect that
      // fires this cycle; the instruction behind it is wrong-path.
      wb_valid_d  = ex_valid & ~flush & ~(wb_valid_q & br_taken);
      // Branch above already used the old flags; update afterwards.
      if (wb_valid_q && fields_q.set_flags) begin
        flag_z_d = fields_q.zero;
        flag_n_d = fields_q.neg;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      fields_q    <= '0;
      wb_valid_q  <= 1'b0;
      flag_z_q    <= 1'b0;
      flag_n_q    <= 1'b0;
      load_held_q <= 1'b0;
      load_data_q <= '0;
    end else begin
      fields_q    <= fields_d;
      wb_valid_q  <= wb_valid_d;
      flag_z_q    <= flag_z_d;
      flag_n_q    <= flag_n_d;
      load_held_q <= load_held_d;
      load_data_q <= load_data_d;
    end
  end

  assign wb_valid       = wb_valid_q;
  assign rf_we          = wb_valid_q & fields_q.reg_write;
  assign rf_waddr       = fields_q.rd;
  assign rf_wdata       = fields_q.mem_to_reg
                          ? (load_held_q ? load_data_q : mem_rdata)
                          : fields_q.result;
  assign flag_z         = flag_z_q;
  assign flag_n         = flag_n_q;
  assign redirect_valid = br_redirect;
  assign redirect_pc    = fields_q.target;

`ifdef WB_FWD_EN
  assign fwd_valid = rf_we;
  assign fwd_rd    = rf_waddr;
  assign fwd_data  = rf_wdata;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed scenarios followed by random
// traffic, all outputs compared each cycle against a transaction model.
module tb_wb_stage;
  import cpu_pkg::*;

  logic            clock = 1'b0;
  logic            reset_n;
  logic            ex_valid, ex_reg_write, ex_mem_to_reg, ex_set_flags;
  logic [RA_W-1:0] ex_rd;
  logic [1:0]      ex_br_type;
  logic [XLEN-1:0] ex_target, ex_result, mem_rdata;
  logic            ex_zero, ex_neg, hold, flush;
  logic            wb_valid, rf_we, flag_z, flag_n, redirect_valid;
  logic [RA_W-1:0] rf_waddr;
  logic [XLEN-1:0] rf_wdata, redirect_pc;
`ifdef WB_FWD_EN
  logic            fwd_valid;
  logic [RA_W-1:0] fwd_rd;
  logic [XLEN-1:0] fwd_data;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  wb_stage dut (
    .clock(clock), .reset_n(reset_n),
    .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
    .ex_mem_to_reg(ex_mem_to_reg), .ex_set_flags(ex_set_flags),
    .ex_br_type(ex_br_type), .ex_target(ex_target), .ex_result(ex_result),
    .ex_zero(ex_zero), .ex_neg(ex_neg), .mem_rdata(mem_rdata),
    .hold(hold), .flush(flush),
    .wb_valid(wb_valid), .rf_we(rf_we), .rf_waddr(rf_waddr),
    .rf_wdata(rf_wdata), .flag_z(flag_z), .flag_n(flag_n),
`ifdef WB_FWD_EN
    .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
`endif
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  // Transaction model: the instruction sitting in WB, the flags, and the
  // copy of load data kept across a stall.
  logic            m_valid, m_rw, m_m2r, m_sf, m_z, m_n, m_fz, m_fn, m_held;
  logic [1:0]      m_br;
  logic [RA_W-1:0] m_rd;
  logic [XLEN-1:0] m_tgt, m_res, m_ldat;

  function automatic bit m_taken();
    return (m_br == 2'd1 && m_fz) || (m_br == 2'd2 && m_fn) || (m_br == 2'd3);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    logic            e_we, e_rv;
    logic [XLEN-1:0] e_wd;
    e_we = m_valid & m_rw;
    e_rv = m_valid && m_taken() && !hold;
    e_wd = !m_m2r ? m_res : (m_held ? m_ldat : mem_rdata);
    chk("wb_valid",       32'(wb_valid),       32'(m_valid));
    chk("rf_we",          32'(rf_we),          32'(e_we));
    chk("rf_waddr",       32'(rf_waddr),       32'(m_rd));
    chk("rf_wdata",       rf_wdata,            e_wd);
    chk("flag_z",         32'(flag_z),         32'(m_fz));
    chk("flag_n",         32'(flag_n),         32'(m_fn));
    chk("redirect_valid", 32'(redirect_valid), 32'(e_rv));
    chk("redirect_pc",    redirect_pc,         m_tgt);
`ifdef WB_FWD_EN
    chk("fwd_valid", 32'(fwd_valid), 32'(e_we));
    chk("fwd_rd",    32'(fwd_rd),    32'(m_rd));
    chk("fwd_data",  fwd_data,       e_wd);
`endif
  endtask

  // Advance one clock and apply the architectural rules to the model using
  // the inputs that were present at the edge.
  task automatic tick();
    bit redir;
    @(posedge clock);
    if (!reset_n) begin
      {m_valid, m_rw, m_m2r, m_sf, m_z, m_n, m_fz, m_fn, m_held} = '0;
      m_br = '0; m_rd = '0; m_tgt = '0; m_res = '0; m_ldat = '0;
    end else if (hold) begin
      if (m_valid && m_m2r && !m_held) begin
        m_ldat = mem_rdata;
        m_held = 1'b1;
      end
    end else begin
      redir = m_valid && m_taken();
      if (m_valid && m_sf) begin
        m_fz = m_z;
        m_fn = m_n;
      end
      m_held  = 1'b0;
      m_valid = ex_valid && !flush && !redir;
      m_rd = ex_rd; m_rw = ex_reg_write; m_m2r = ex_mem_to_reg;
      m_sf = ex_set_flags; m_br = ex_br_type; m_tgt = ex_target;
      m_res = ex_result; m_z = ex_zero; m_n = ex_neg;
    end
    #1;
  endtask

  task automatic set_ex(input logic v, input logic [RA_W-1:0] rd, input logic rw,
                        input logic m2r, input logic sf, input logic [1:0] br,
                        input logic [XLEN-1:0] tgt, input logic [XLEN-1:0] res,
                        input logic z, input logic n);
    ex_valid = v; ex_rd = rd; ex_reg_write = rw; ex_mem_to_reg = m2r;
    ex_set_flags = sf; ex_br_type = br; ex_target = tgt; ex_result = res;
    ex_zero = z; ex_neg = n;
  endtask

  task automatic idle();
    set_ex(1'b0, '0, 1'b0, 1'b0, 1'b0, 2'd0, '0, '0, 1'b0, 1'b0);
  endtask

  initial begin
    reset_n = 1'b0; hold = 1'b0; flush = 1'b0; mem_rdata = '0;
    idle();
    tick(); tick();
    reset_n = 1'b1;
    #1 check_model();
    chk("reset_we",  32'(rf_we), 32'd0);
    chk("reset_wd",  rf_wdata, 32'd0);
    chk("reset_pc",  redirect_pc, 32'd0);
    chk("reset_fz",  32'(flag_z), 32'd0);

    // ALU writeback
    set_ex(1'b1, 6'd5, 1'b1, 1'b0, 1'b0, 2'd0, '0, 32'h2A, 1'b0, 1'b0);
    tick(); idle();
    #1 check_model();
    chk("alu_we", 32'(rf_we), 32'd1);
    chk("alu_wa", 32'(rf_waddr), 32'd5);
    chk("alu_wd", rf_wdata, 32'h2A);
`ifdef WB_FWD_EN
    set_ex(1'b1, 6'd7, 1'b1, 1'b0, 1'b0, 2'd0, '0, 32'h13, 1'b0, 1'b0);
    tick(); idle();
    #1 check_model();
    chk("fwd_vld", 32'(fwd_valid), 32'd1);
    chk("fwd_rd7", 32'(fwd_rd), 32'd7);
    chk("fwd_d13", fwd_data, 32'h13);
`endif
    tick();

    // SUB sets Z, BRZ taken, the follower is squashed
    set_ex(1'b1, 6'd1, 1'b1, 1'b0, 1'b1, 2'd0, '0, 32'h0, 1'b1, 1'b0);
    tick();
    set_ex(1'b1, 6'd0, 1'b0, 1'b0, 1'b0, 2'd1, 32'h100, '0, 1'b0, 1'b0);
    tick();
    set_ex(1'b1, 6'd2, 1'b1, 1'b0, 1'b0, 2'd0, '0, 32'h77, 1'b0, 1'b0);
    #1 check_model();
    chk("brz_rv", 32'(redirect_valid), 32'd1);
    chk("brz_pc", redirect_pc, 32'h100);
    tick(); idle();
    #1 check_model();
    chk("brz_squash", 32'(wb_valid), 32'd0);
    tick();

    // N cleared, BRN not taken, follower retires
    set_ex(1'b1, 6'd1, 1'b1, 1'b0, 1'b1, 2'd0, '0, 32'h5, 1'b0, 1'b0);
    tick();
    set_ex(1'b1, 6'd0, 1'b0, 1'b0, 1'b0, 2'd2, 32'h200, '0, 1'b0, 1'b0);
    tick();
    set_ex(1'b1, 6'd4, 1'b1, 1'b0, 1'b0, 2'd0, '0, 32'h99, 1'b0, 1'b0);
    #1 check_model();
    chk("brn_rv", 32'(redirect_valid), 32'd0);
    tick(); idle();
    #1 check_model();
    chk("brn_next_vld", 32'(wb_valid), 32'd1);
    chk("brn_next_wd", rf_wdata, 32'h99);

    // Load under a three-cycle hold
    set_ex(1'b1, 6'd3, 1'b1, 1'b1, 1'b0, 2'd0, '0, '0, 1'b0, 1'b0);
    tick();
    set_ex(1'b1, 6'd9, 1'b1, 1'b0, 1'b1, 2'd0, '0, 32'h55, 1'b1, 1'b1);
    hold = 1'b1; mem_rdata = 32'd30;
    #1 check_model();
    chk("ld_wd0", rf_wdata, 32'd30);
    tick();
    mem_rdata = 32'hDEAD;
    for (int i = 0; i < 2; i++) begin
      #1 check_model();
      chk("ld_wd_hold", rf_wdata, 32'd30);
      chk("ld_fz_hold", 32'(flag_z), 32'd0);
      tick();
    end
    hold = 1'b0;
    #1 check_model();
    chk("ld_wd_rel", rf_wdata, 32'd30);
    chk("ld_wa_rel", 32'(rf_waddr), 32'd3);
    tick(); idle();
    #1 check_model();
    chk("ld_next_wa", 32'(rf_waddr), 32'd9);
    chk("ld_next_wd", rf_wdata, 32'h55);
    tick();
    #1 check_model();
    chk("ld_next_fz", 32'(flag_z), 32'd1);

    // Reset mid-stream
    set_ex(1'b1, 6'd6, 1'b1, 1'b0, 1'b0, 2'd0, '0, 32'h5, 1'b0, 1'b0);
    tick(); idle();
    #1 chk("pre_rst_vld", 32'(wb_valid), 32'd1);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    #1 check_model();
    chk("rst_vld", 32'(wb_valid), 32'd0);
    chk("rst_fz",  32'(flag_z), 32'd0);
    chk("rst_we",  32'(rf_we), 32'd0);
    chk("rst_rv",  32'(redirect_valid), 32'd0);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      reset_n   = ($urandom_range(39) != 0);
      hold      = ($urandom_range(3) == 0);
      flush     = ($urandom_range(7) == 0);
      mem_rdata = $urandom;
      set_ex(1'($urandom), 6'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
             2'($urandom), $urandom, $urandom, 1'($urandom), 1'($urandom));
      #1 check_model();
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
